// File: rtl/horner_stream_loader.sv
// Ingest stage for the horner core: splits one AXI-Stream frame into header, weight,
// matrix and vector segments and drives registered write ports into the core buffers.
module horner_stream_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int ORI_NUM    = 8,
    parameter int INT_NUM    = 35,
    parameter int LAY_NUM    = 5,
    parameter int AW         = 6
) (
    input  logic                        s00_axis_aclk,
    input  logic                        s00_axis_reset,
    input  logic [LANES*DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                        s00_axis_tvalid,
    output logic                        s00_axis_tready,
    input  logic                        s00_axis_tlast,
    input  logic                        core_busy,
    output logic [31:0]                 cal_num,
    output logic                        w_we,
    output logic [AW-1:0]               w_addr,
    output logic [31:0]                 w_data,
    output logic                        m_we,
    output logic [1:0]                  m_addr,
    output logic [LANES*DATA_WIDTH-1:0] m_data,
    output logic                        v_we,
    output logic [AW-1:0]               v_addr,
    output logic [LANES*DATA_WIDTH-1:0] v_data,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic                        err_tlast,
    output logic                        err_wovf
);
    localparam int BEAT_W     = LANES * DATA_WIDTH;
    localparam int WEIGHT_NUM = 3 * ORI_NUM + INT_NUM - LAY_NUM + 3;
    localparam int VEC_NUM    = ORI_NUM + INT_NUM + LAY_NUM + 3;
    localparam logic [AW-1:0] W_LAST = AW'(WEIGHT_NUM - 1);
    localparam logic [AW-1:0] M_LAST = AW'(2);
    localparam logic [AW-1:0] V_LAST = AW'(VEC_NUM - 1);

    localparam logic [2:0] ST_HDR   = 3'd0;
    localparam logic [2:0] ST_WGT   = 3'd1;
    localparam logic [2:0] ST_MAT   = 3'd2;
    localparam logic [2:0] ST_VEC   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // A weight fits in 32 bits when bits [63:31] are a pure sign extension.
    function automatic logic fits_q32(input logic [BEAT_W-1:0] d);
        return (&d[BEAT_W-1:31]) || !(|d[BEAT_W-1:31]);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              drain_first_q, drain_first_d;
    logic              tready_q, tready_d;
    logic [31:0]       cal_num_q, cal_num_d;
    logic              w_we_q, w_we_d;
    logic [AW-1:0]     w_addr_q, w_addr_d;
    logic [31:0]       w_data_q, w_data_d;
    logic              m_we_q, m_we_d;
    logic [1:0]        m_addr_q, m_addr_d;
    logic [BEAT_W-1:0] m_data_q, m_data_d;
    logic              v_we_q, v_we_d;
    logic [AW-1:0]     v_addr_q, v_addr_d;
    logic [BEAT_W-1:0] v_data_q, v_data_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              err_tlast_q, err_tlast_d;
    logic              err_wovf_q, err_wovf_d;
    logic              accept;

    // Gating with reset keeps tready low throughout the reset cycle itself.
    assign s00_axis_tready = tready_q && !s00_axis_reset;
    assign accept          = s00_axis_tvalid && s00_axis_tready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        drain_first_d = drain_first_q;
        cal_num_d     = cal_num_q;
        w_we_d        = 1'b0;
        w_addr_d      = w_addr_q;
        w_data_d      = w_data_q;
        m_we_d        = 1'b0;
        m_addr_d      = m_addr_q;
        m_data_d      = m_data_q;
        v_we_d        = 1'b0;
        v_addr_d      = v_addr_q;
        v_data_d      = v_data_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        err_tlast_d   = err_tlast_q;
        err_wovf_d    = err_wovf_q;

        case (state_q)
            ST_HDR: if (accept) begin
                cal_num_d     = s00_axis_tdata[31:0];
                cnt_d         = '0;
                frame_start_d = 1'b1;
                state_d       = ST_WGT;
            end
            ST_WGT: if (accept) begin
                w_we_d   = 1'b1;
                w_addr_d = cnt_q;
                w_data_d = s00_axis_tdata[31:0];
                if (!fits_q32(s00_axis_tdata)) err_wovf_d = 1'b1;
                if (cnt_q == W_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_MAT;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_MAT: if (accept) begin
                m_we_d   = 1'b1;
                m_addr_d = cnt_q[1:0];
                m_data_d = s00_axis_tdata;
                if (cnt_q == M_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_VEC;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_VEC: if (accept) begin
                v_we_d   = 1'b1;
                v_addr_d = cnt_q;
                v_data_d = s00_axis_tdata;
                if (cnt_q == V_LAST) begin
                    frame_done_d  = 1'b1;
                    drain_first_d = 1'b1;
                    state_d       = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                // The first drain cycle is unconditional so the core has time to raise busy.
                drain_first_d = 1'b0;
                if (!drain_first_q && !core_busy) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase

        if (accept && s00_axis_tlast && !(state_q == ST_VEC && cnt_q == V_LAST))
            err_tlast_d = 1'b1;

        tready_d = (state_d != ST_DRAIN);
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_reset) begin
            state_q       <= ST_HDR;
            cnt_q         <= '0;
            drain_first_q <= 1'b0;
            tready_q      <= 1'b0;
            cal_num_q     <= '0;
            w_we_q        <= 1'b0;
            w_addr_q      <= '0;
            w_data_q      <= '0;
            m_we_q        <= 1'b0;
            m_addr_q      <= '0;
            m_data_q      <= '0;
            v_we_q        <= 1'b0;
            v_addr_q      <= '0;
            v_data_q      <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_tlast_q   <= 1'b0;
            err_wovf_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            drain_first_q <= drain_first_d;
            tready_q      <= tready_d;
            cal_num_q     <= cal_num_d;
            w_we_q        <= w_we_d;
            w_addr_q      <= w_addr_d;
            w_data_q      <= w_data_d;
            m_we_q        <= m_we_d;
            m_addr_q      <= m_addr_d;
            m_data_q      <= m_data_d;
            v_we_q        <= v_we_d;
            v_addr_q      <= v_addr_d;
            v_data_q      <= v_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            err_tlast_q   <= err_tlast_d;
            err_wovf_q    <= err_wovf_d;
        end
    end

    assign cal_num     = cal_num_q;
    assign w_we        = w_we_q;
    assign w_addr      = w_addr_q;
    assign w_data      = w_data_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_data      = m_data_q;
    assign v_we        = v_we_q;
    assign v_addr      = v_addr_q;
    assign v_data      = v_data_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign err_tlast   = err_tlast_q;
    assign err_wovf    = err_wovf_q;
endmodule

// File: tb/tb_horner_stream_loader.sv
// Scoreboard bench for horner_stream_loader: every accepted beat pushes its expected
// write, and the negedge monitor pops and compares each strobe as it appears.
module tb_horner_stream_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;
    logic        core_busy = 1'b0;
    logic [31:0] cal_num;
    logic        w_we, m_we, v_we, frame_start, frame_done, err_tlast, err_wovf;
    logic [5:0]  w_addr, v_addr;
    logic [1:0]  m_addr;
    logic [31:0] w_data;
    logic [63:0] m_data, v_data;

    horner_stream_loader dut (
        .s00_axis_aclk(clk), .s00_axis_reset(rst), .s00_axis_tdata(tdata),
        .s00_axis_tvalid(tvalid), .s00_axis_tready(tready), .s00_axis_tlast(tlast),
        .core_busy(core_busy), .cal_num(cal_num),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .m_we(m_we), .m_addr(m_addr), .m_data(m_data),
        .v_we(v_we), .v_addr(v_addr), .v_data(v_data),
        .frame_start(frame_start), .frame_done(frame_done),
        .err_tlast(err_tlast), .err_wovf(err_wovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0, hdr_acc_cyc = 0;
    logic [31:0] exp_cal = '0;
    int          w_cnt = 0, m_cnt = 0, v_cnt = 0, fs_cnt = 0, fd_cnt = 0;
    bit          busy_mode = 1'b0;
    int          busy_left = 0, busy_fall_cyc = 0;
    logic [63:0] w24_seen = '0, w5_seen = '0;
    logic [63:0] w_words[57];
    logic [63:0] m_words[3];
    logic [63:0] v_words[51];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input int addr, input logic [63:0] data);
        exp_t e;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_kind", 64'(kind), 64'(e.kind));
            check("sb_addr", 64'(addr), 64'(e.addr));
            check("sb_data", data, e.data);
            check("sb_latency", 64'(cyc), 64'(e.cyc + 1));
        end
    endtask

    always @(negedge clk) begin
        if (w_we) begin
            w_cnt++;
            if (w_addr == 6'd24) w24_seen = {32'h0, w_data};
            if (w_addr == 6'd5)  w5_seen  = {32'h0, w_data};
            sb_pop(0, int'(w_addr), {32'h0, w_data});
        end
        if (m_we) begin
            m_cnt++;
            sb_pop(1, int'(m_addr), m_data);
        end
        if (v_we) begin
            v_cnt++;
            sb_pop(2, int'(v_addr), v_data);
        end
        if (frame_start) begin
            fs_cnt++;
            check("fs_latency", 64'(cyc), 64'(hdr_acc_cyc + 1));
            check("cal_at_fs", 64'(cal_num), 64'(exp_cal));
        end
        if (frame_done) begin
            fd_cnt++;
            check("fd_with_vwe", 64'(v_we), 64'd1);
            check("fd_vaddr", 64'(v_addr), 64'd50);
            if (busy_mode) begin
                core_busy = 1'b1;
                busy_left = 40;
            end
        end else if (busy_left > 0) begin
            check("tready_busy", 64'(tready), 64'd0);
            check("cal_hold", 64'(cal_num), 64'(exp_cal));
            busy_left--;
            if (busy_left == 0) begin
                core_busy     = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    task automatic build_frame();
        for (int i = 0; i < 57; i++) w_words[i] = 64'(longint'(i * 1000 - 20000));
        w_words[0]  = 64'(longint'(90816));
        w_words[24] = 64'(longint'(-803416));
        m_words[0]  = {16'd41, 16'd0, 16'd0, 16'hB000};
        m_words[1]  = {$urandom, $urandom};
        m_words[2]  = {$urandom, $urandom};
        v_words[0]  = {16'd1, 16'd500, 16'd800, 16'd300};
        for (int i = 1; i < 51; i++) v_words[i] = {$urandom, $urandom};
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input int gap_pct,
                             output bit ok);
        ok = 1'b0;
        if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
            repeat ($urandom_range(3, 1)) begin
                @(negedge clk);
                tvalid = 1'b0;
            end
        end
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            tvalid  = 1'b1;
            tdata   = d;
            tlast   = last;
            acc_cyc = cyc;
            ok      = tready;
            @(posedge clk);
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input logic [31:0] hdr, input int gap_pct, input int tlast_beat,
                              input int abort_beat, input bit final_last);
        logic [63:0] d;
        bit          ok;
        exp_t        e;
        for (int b = 0; b < 112; b++) begin
            if (b == abort_beat) break;
            if (b == 0)       d = {32'h0, hdr};
            else if (b <= 57) d = w_words[b - 1];
            else if (b <= 60) d = m_words[b - 58];
            else              d = v_words[b - 61];
            send_beat(d, (b == tlast_beat) || (b == 111 && final_last), gap_pct, ok);
            if (!ok) break;
            if (b == 0) begin
                hdr_acc_cyc = acc_cyc;
                exp_cal     = hdr;
            end else begin
                e.cyc = acc_cyc;
                if (b <= 57) begin
                    e.kind = 0; e.addr = b - 1;  e.data = {32'h0, d[31:0]};
                end else if (b <= 60) begin
                    e.kind = 1; e.addr = b - 58; e.data = d;
                end else begin
                    e.kind = 2; e.addr = b - 61; e.data = d;
                end
                sb.push_back(e);
            end
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic end_frame(input int exp_v, input int exp_fd);
        repeat (3) @(negedge clk);
        check("w_we_count", 64'(w_cnt), 64'd57);
        check("m_we_count", 64'(m_cnt), 64'd3);
        check("v_we_count", 64'(v_cnt), 64'(exp_v));
        check("frame_start_count", 64'(fs_cnt), 64'd1);
        check("frame_done_count", 64'(fd_cnt), 64'(exp_fd));
        check("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        w_cnt = 0; m_cnt = 0; v_cnt = 0; fs_cnt = 0; fd_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 check("tready_in_reset", 64'(tready), 64'd0);
        @(negedge clk);
        check("tready_after_rst_edge", 64'(tready), 64'd0);
        check("cal_num_reset", 64'(cal_num), 64'd0);
        check("err_tlast_reset", 64'(err_tlast), 64'd0);
        check("err_wovf_reset", 64'(err_wovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_post_reset", 64'(tready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_frame();
        repeat (2) @(negedge clk);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_strobes", 64'({w_we, m_we, v_we, frame_start, frame_done}), 64'd0);
        check("rst_addrs", 64'({w_addr, m_addr, v_addr}), 64'd0);
        check("rst_data", 64'(w_data) | m_data | v_data, 64'd0);
        check("rst_cal_num", 64'(cal_num), 64'd0);
        check("rst_errs", 64'({err_tlast, err_wovf}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_first", 64'(tready), 64'd1);

        // Nominal contiguous frame.
        send_frame(32'd3, 0, -1, -1, 1'b1);
        end_frame(51, 1);
        check("nom_cal_num", 64'(cal_num), 64'd3);
        check("nom_w24", w24_seen, 64'h0000_0000_FFF3_BDA8);
        check("nom_err_tlast", 64'(err_tlast), 64'd0);
        check("nom_err_wovf", 64'(err_wovf), 64'd0);

        // Same frame with random idle gaps.
        send_frame(32'd3, 50, -1, -1, 1'b1);
        end_frame(51, 1);

        // Core busy for 40 cycles after frame_done blocks the next header.
        busy_mode = 1'b1;
        send_frame(32'd7, 0, -1, -1, 1'b1);
        end_frame(51, 1);
        busy_mode = 1'b0;
        send_frame(32'd7, 0, -1, -1, 1'b1);
        check("hdr_after_busy", 64'(hdr_acc_cyc > busy_fall_cyc), 64'd1);
        end_frame(51, 1);

        // tlast on weight beat 10 only; cal_num 0 is a legal header.
        send_frame(32'd0, 0, 11, -1, 1'b0);
        end_frame(51, 1);
        check("tlast_err_set", 64'(err_tlast), 64'd1);
        check("tlast_cal_zero", 64'(cal_num), 64'd0);
        send_frame(32'd5, 0, -1, -1, 1'b1);
        end_frame(51, 1);
        check("tlast_err_sticky", 64'(err_tlast), 64'd1);
        do_reset();
        check("tlast_err_cleared", 64'(err_tlast), 64'd0);

        // Weight width rule.
        w_words[6] = 64'hFFFF_FFFF_FFFF_FFFF;
        send_frame(32'd9, 0, -1, -1, 1'b1);
        end_frame(51, 1);
        check("wovf_all_ones", 64'(err_wovf), 64'd0);
        w_words[5] = 64'h0000_0000_8000_0000;
        send_frame(32'd9, 0, -1, -1, 1'b1);
        end_frame(51, 1);
        check("wovf_w5_data", w5_seen, 64'h0000_0000_8000_0000);
        check("wovf_set", 64'(err_wovf), 64'd1);
        build_frame();
        do_reset();

        // Reset at vector index 20, then a fresh full frame.
        send_frame(32'd11, 0, -1, 81, 1'b1);
        @(negedge clk);
        do_reset();
        end_frame(20, 0);
        send_frame(32'd12, 30, -1, -1, 1'b1);
        end_frame(51, 1);
        check("post_reset_cal", 64'(cal_num), 64'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/horner_stream_loader.md
Name: horner_stream_loader

Overview:
- Upstream ingest stage of the horner compute top. Parses one AXI-Stream frame into header, weight, matrix and vector segments, and drives write ports into the core's weight, matrix and vector buffers.
- Frame format: 1 header word (CAL_NUM), then WEIGHT_NUM weight words, then 3 matrix rows, then VEC_NUM vector words.
- Pulses frame_start and frame_done to the compute core, and back-pressures the next frame until the core is idle.

Parameters:
- DATA_WIDTH, 16, width of one lane.
- LANES, 4, lanes per beat; beat width is LANES*DATA_WIDTH = 64.
- ORI_NUM, 8, orientation entries.
- INT_NUM, 35, interface entries.
- LAY_NUM, 5, layers.
- WEIGHT_NUM, 3*ORI_NUM+INT_NUM-LAY_NUM+3 (57), weight words per frame; derived.
- VEC_NUM, ORI_NUM+INT_NUM+LAY_NUM+3 (51), vector words per frame; derived.
- AW, 6, address width for the weight and vector ports; must satisfy 2^AW >= max(WEIGHT_NUM, VEC_NUM).

Ports:
- s00_axis_aclk  in  1  single clock.
- s00_axis_reset  in  1  synchronous, active-high reset.
- s00_axis_tdata  in  64  stream data.
- s00_axis_tvalid  in  1  stream valid.
- s00_axis_tready  out  1  stream ready.
- s00_axis_tlast  in  1  stream last; used for checking only.
- core_busy  in  1  compute core is running a frame.
- cal_num  out  32  latched header, tdata[31:0].
- w_we  out  1  weight write strobe.
- w_addr  out  AW  weight index.
- w_data  out  32  signed Q16 weight, tdata[31:0].
- m_we  out  1  matrix write strobe.
- m_addr  out  2  matrix row, 0..2.
- m_data  out  64  matrix row, 4 lanes of 16 bits, raw.
- v_we  out  1  vector write strobe.
- v_addr  out  AW  vector index.
- v_data  out  64  vector word, raw.
- frame_start  out  1  one-cycle pulse.
- frame_done  out  1  one-cycle pulse.
- err_tlast  out  1  sticky flag: tlast seen on a non-final beat.
- err_wovf  out  1  sticky flag: weight does not fit in 32 bits.

Behaviour:
- Beat accepted when tvalid && tready. No beat is lost or duplicated under arbitrary tvalid gaps.
- FSM states: HDR, WGT, MAT, VEC, DRAIN.
  - Reset enters HDR. s00_axis_tready=1 in HDR, WGT, MAT and VEC; 0 in DRAIN.
  - HDR: on accept, cal_num<=tdata[31:0], counter<=0, go to WGT. frame_start pulses the following cycle.
  - WGT: each accept writes index=counter. After WEIGHT_NUM-1 is accepted, counter<=0 and go to MAT.
  - MAT: each accept writes row=counter. After row 2 is accepted, counter<=0 and go to VEC.
  - VEC: each accept writes index=counter. After VEC_NUM-1 is accepted, go to DRAIN.
  - DRAIN: stays at least 1 cycle. Returns to HDR on the first cycle from the 2nd DRAIN cycle onward in which core_busy==0. The core must raise core_busy by the cycle after frame_done.
- Write timing: outputs are registered. The strobe, address and data appear exactly 1 cycle after the accepting edge, and each strobe is a single-cycle pulse. frame_done is asserted in the same cycle as the final v_we.
- Segment boundaries are count-based; tlast does not terminate a frame.
  - tlast=1 on any accepted beat other than the final vector sets err_tlast; that beat is still processed normally.
  - A missing tlast on the final vector is not an error.
- Weight width rule: w_data=tdata[31:0]. err_wovf is set if tdata[63:31] is not all-zeros or all-ones. The data is not saturated, only truncated.
- Sticky flags clear only on reset.
- Reset values: all strobes and pulses 0, all addresses and data 0, cal_num=0, err flags 0.
- tready reset value: 0 during the reset cycle; 1 from the first cycle after reset deasserts.
- Reset mid-frame: the partial frame is discarded, no frame_done is issued, counters clear, and the loader expects a fresh header.
- cal_num=0 is legal and is loaded normally.
- cal_num is held until the next header and is stable from frame_start through the next header acceptance.

Test Plan:
- Nominal frame: header 3, weights[0]=90816, weights[24]=-803416, matrix row0 {-20480,0,0,41}, vec[0] lanes {300,800,500,1}, all contiguous -> exactly 57 w_we (addr 0..56, w_data[24]=0xFFF3BDA8), 3 m_we, 51 v_we, cal_num=3, one frame_start, one frame_done, both err flags 0.
- Random tvalid gaps (~50% idle) on the same frame -> identical write sequence; strobes appear only 1 cycle after each accept.
- Back-to-back frame with core_busy=1 for 40 cycles after frame_done -> tready=0 for the whole busy window; next header accepted only after core_busy falls; second frame writes match the first.
- tlast on weight beat 10, none at the end -> err_tlast=1, frame still completes with 57/3/51 writes; flag survives into the next frame and clears on reset.
- Weight word 0x0000_0000_8000_0000 -> w_data=0x80000000, err_wovf=1; weight 0xFFFF_FFFF_FFFF_FFFF -> no flag.
- Reset asserted at vector index 20 -> no frame_done; tready=0 during the reset cycle and 1 afterwards; a new full frame then completes normally with v_addr restarting at 0.
